// File: rtl/word_asm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : word_asm_pkg
// Description : Shared widths, word type and parity helper for the
//               word_assembler packer and its output FIFO.
//               Optional feature macro: WORD_ASM_PARITY_EN (widens each FIFO
//               entry by one parity bit).
// Revision    : 1.0 - initial release
// ============================================================================
package word_asm_pkg;

    localparam int BYTE_W         = 8;
    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;

    typedef logic [WORD_W-1:0] word_t;

`ifdef WORD_ASM_PARITY_EN
    // Each entry carries the word plus its even-parity bit in the MSB.
    localparam int ENTRY_W = WORD_W + 1;
`else
    localparam int ENTRY_W = WORD_W;
`endif

    // XOR reduction of a whole word.
    function automatic logic word_parity(input word_t w);
        return ^w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/word_asm_fifo.sv
`default_nettype none
// ============================================================================
// Module      : word_asm_fifo
// Description : Synchronous first-word-fall-through FIFO. The head entry is
//               presented on o_rdata whenever the FIFO is non-empty, and
//               o_rdata reads zero when empty. A push while full is accepted
//               only if a pop happens in the same cycle; otherwise it is
//               dropped and the stored contents are left untouched.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               i_push, i_wdata - write request and data
//               i_pop           - read request (ignored when empty)
//               o_rdata         - head entry (zero when empty)
//               o_level         - occupancy 0..DEPTH
//               o_full, o_empty - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module word_asm_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int c_ptr_w = $clog2(DEPTH);

    logic [WIDTH-1:0]   r_mem_q [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr_q, w_wr_ptr_d;
    logic [c_ptr_w-1:0] r_rd_ptr_q, w_rd_ptr_d;
    logic [c_ptr_w:0]   r_level_q,  w_level_d;
    logic               w_push_ok;
    logic               w_pop_ok;

    assign o_empty = (r_level_q == '0);
    assign o_full  = (r_level_q == (c_ptr_w+1)'(DEPTH));
    assign o_level = r_level_q;
    assign o_rdata = o_empty ? '0 : r_mem_q[r_rd_ptr_q];

    // A pop frees the head slot in the same cycle, so a simultaneous push
    // into a full FIFO still has room.
    assign w_pop_ok  = i_pop & ~o_empty;
    assign w_push_ok = i_push & (~o_full | w_pop_ok);

    always_comb begin
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_level_d  = r_level_q;
        // DEPTH is a power of two, so pointers wrap by natural overflow.
        if (w_push_ok) w_wr_ptr_d = r_wr_ptr_q + c_ptr_w'(1);
        if (w_pop_ok)  w_rd_ptr_d = r_rd_ptr_q + c_ptr_w'(1);
        if (w_push_ok && !w_pop_ok)      w_level_d = r_level_q + (c_ptr_w+1)'(1);
        else if (!w_push_ok && w_pop_ok) w_level_d = r_level_q - (c_ptr_w+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_level_q  <= '0;
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_level_q  <= w_level_d;
        end
    end

    // Storage needs no reset: nothing is visible until level goes non-zero.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem_q[r_wr_ptr_q] <= i_wdata;
    end

endmodule
`default_nettype wire

// File: rtl/word_assembler.sv
`default_nettype none
// ============================================================================
// Module      : word_assembler
// Description : Packs a stream of bytes big-endian into 32-bit words (first
//               byte -> bits 31:24) and queues completed words in a FWFT
//               FIFO with a valid/ready output. Words arriving while the FIFO
//               is full (and not being drained) are dropped and latch the
//               sticky overflow flag, which only reset clears.
//               Optional feature macro: WORD_ASM_PARITY_EN adds dout_par.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               din, din_en     - input byte and its valid strobe
//               dout, dout_vld  - head-of-FIFO word and valid
//               dout_rdy        - downstream accept
//               level           - FIFO occupancy 0..DEPTH
//               overflow        - sticky word-dropped flag
//               dout_par        - XOR of dout (WORD_ASM_PARITY_EN only)
// Revision    : 1.0 - initial release
// ============================================================================
module word_assembler
    import word_asm_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [BYTE_W-1:0]      din,
    input  logic                   din_en,
    output logic [WORD_W-1:0]      dout,
    output logic                   dout_vld,
    input  logic                   dout_rdy,
    output logic [$clog2(DEPTH):0] level,
`ifdef WORD_ASM_PARITY_EN
    output logic                   dout_par,
`endif
    output logic                   overflow
);

    localparam int c_idx_w  = $clog2(BYTES_PER_WORD);
    localparam int c_part_w = (BYTES_PER_WORD - 1) * BYTE_W;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(BYTES_PER_WORD - 1);

    logic [c_idx_w-1:0]  r_byte_idx_q, w_byte_idx_d;
    logic [c_part_w-1:0] r_part_q,     w_part_d;
    logic                r_overflow_q, w_overflow_d;
    logic                w_push;
    logic                w_pop;
    word_t               w_word;
    logic [ENTRY_W-1:0]  w_wdata;
    logic [ENTRY_W-1:0]  w_rdata;
    logic                w_full;
    logic                w_empty;

    // The three earlier bytes sit in r_part_q oldest-first, so the finished
    // word is simply the partial register with the current byte appended.
    assign w_word = {r_part_q, din};

    always_comb begin
        w_byte_idx_d = r_byte_idx_q;
        w_part_d     = r_part_q;
        w_push       = 1'b0;
        if (din_en) begin
            w_part_d = {r_part_q[c_part_w-BYTE_W-1:0], din};
            if (r_byte_idx_q == c_last_idx) begin
                w_byte_idx_d = '0;
                w_push       = 1'b1;
            end else begin
                w_byte_idx_d = r_byte_idx_q + c_idx_w'(1);
            end
        end
    end

    assign w_pop        = dout_rdy & ~w_empty;
    // A word is lost only when the FIFO is full and nothing leaves this cycle.
    assign w_overflow_d = r_overflow_q | (w_push & w_full & ~w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_byte_idx_q <= '0;
            r_part_q     <= '0;
            r_overflow_q <= 1'b0;
        end else begin
            r_byte_idx_q <= w_byte_idx_d;
            r_part_q     <= w_part_d;
            r_overflow_q <= w_overflow_d;
        end
    end

`ifdef WORD_ASM_PARITY_EN
    assign w_wdata  = {word_parity(w_word), w_word};
    // FIFO returns all-zero when empty, so parity also reads 0 then.
    assign dout_par = w_rdata[WORD_W];
`else
    assign w_wdata  = w_word;
`endif

    word_asm_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_level (level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign dout     = w_rdata[WORD_W-1:0];
    assign dout_vld = ~w_empty;
    assign overflow = r_overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_word_assembler.sv
`default_nettype none
// ============================================================================
// Module      : tb_word_assembler
// Description : Self-checking bench for word_assembler (DEPTH = 4). Directed
//               scenarios plus randomized traffic compared against a
//               queue-based reference model of byte packing and a bounded
//               word queue. Honours WORD_ASM_PARITY_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_word_assembler;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic [7:0]  din;
    logic        din_en;
    logic [31:0] dout;
    logic        dout_vld;
    logic        dout_rdy;
    logic [2:0]  level;
    logic        overflow;
    logic        dout_par;

    int checks = 0;
    int errors = 0;

    // Reference model: bytes collected so far, queued words, sticky flag.
    logic [7:0]  mb[$];
    logic [31:0] mq[$];
    bit          m_ovf;

    word_assembler #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .din_en   (din_en),
        .dout     (dout),
        .dout_vld (dout_vld),
        .dout_rdy (dout_rdy),
        .level    (level),
`ifdef WORD_ASM_PARITY_EN
        .dout_par (dout_par),
`endif
        .overflow (overflow)
    );

`ifndef WORD_ASM_PARITY_EN
    assign dout_par = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one clock of stimulus, advance the model at the edge, and leave
    // time 1 unit past the edge for sampling.
    task automatic cycle(input logic en, input logic [7:0] b, input logic rdy);
        logic [31:0] w;
        din_en   = en;
        din      = b;
        dout_rdy = rdy;
        @(posedge clk);
        if (rst) begin
            mb.delete();
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            if (rdy && mq.size() > 0) void'(mq.pop_front());
            if (en) begin
                mb.push_back(b);
                if (mb.size() == 4) begin
                    w = {mb[0], mb[1], mb[2], mb[3]};
                    mb.delete();
                    if (mq.size() < DEPTH) mq.push_back(w);
                    else m_ovf = 1'b1;
                end
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        // Traffic during reset must be ignored.
        cycle(1'b1, 8'($urandom), 1'b1);
        cycle(1'b1, 8'($urandom), 1'b0);
        rst = 1'b0;
        din_en = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (dout_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got=%b exp=0", dout_vld); end
        checks++; if (dout !== 32'h0) begin errors++; $display("FAIL reset_dout got=%h exp=00000000", dout); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
        cycle(1'b0, 8'h00, 1'b1);   // ready with empty FIFO: no effect
        checks++; if (level !== 3'd0 || dout_vld !== 1'b0) begin errors++; $display("FAIL empty_pop level=%0d vld=%b exp=0/0", level, dout_vld); end
    endtask

    task automatic test_basic();
        logic [7:0] bytes [4] = '{8'h12, 8'h34, 8'h56, 8'h78};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            checks++; if (dout_vld !== 1'b0) begin errors++; $display("FAIL basic_early_vld byte=%0d got=%b exp=0", i, dout_vld); end
            cycle(1'b1, bytes[i], 1'b1);
        end
        checks++; if (dout_vld !== 1'b1 || dout !== 32'h12345678) begin errors++; $display("FAIL basic_word vld=%b dout=%h exp=1/12345678", dout_vld, dout); end
        cycle(1'b0, 8'h00, 1'b1);
        checks++; if (dout_vld !== 1'b0 || dout !== 32'h0) begin errors++; $display("FAIL basic_one_cycle vld=%b dout=%h exp=0/00000000", dout_vld, dout); end
    endtask

    task automatic test_gaps();
        logic [7:0] bytes [4] = '{8'h12, 8'h34, 8'h56, 8'h78};
        int gap;
        for (int rep = 0; rep < 3; rep++) begin
            do_reset();
            for (int i = 0; i < 4; i++) begin
                gap = $urandom_range(0, 3);
                for (int g = 0; g < gap; g++) begin
                    cycle(1'b0, 8'($urandom), 1'b1);
                    checks++; if (dout_vld !== 1'b0) begin errors++; $display("FAIL gaps_spurious_vld rep=%0d got=%b exp=0", rep, dout_vld); end
                end
                cycle(1'b1, bytes[i], 1'b1);
            end
            checks++; if (dout_vld !== 1'b1 || dout !== 32'h12345678) begin errors++; $display("FAIL gaps_word rep=%0d vld=%b dout=%h exp=1/12345678", rep, dout_vld, dout); end
            cycle(1'b0, 8'h00, 1'b1);
            checks++; if (dout_vld !== 1'b0) begin errors++; $display("FAIL gaps_extra_vld rep=%0d got=%b exp=0", rep, dout_vld); end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] exp;
        do_reset();
        for (int i = 0; i < 20; i++) cycle(1'b1, 8'(i), 1'b0);
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL ovf_level got=%0d exp=4", level); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        for (int k = 0; k < 4; k++) begin
            exp = {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)};
            checks++; if (dout_vld !== 1'b1 || dout !== exp) begin errors++; $display("FAIL ovf_drain k=%0d vld=%b dout=%h exp=1/%h", k, dout_vld, dout, exp); end
            cycle(1'b0, 8'h00, 1'b1);
        end
        checks++; if (level !== 3'd0 || dout_vld !== 1'b0) begin errors++; $display("FAIL ovf_empty level=%0d vld=%b exp=0/0", level, dout_vld); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] exp [4] = '{32'h24252627, 32'h28292A2B, 32'h2C2D2E2F, 32'hA0A1A2A3};
        do_reset();
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0);
        cycle(1'b1, 8'hA0, 1'b0);
        cycle(1'b1, 8'hA1, 1'b0);
        cycle(1'b1, 8'hA2, 1'b0);
        cycle(1'b1, 8'hA3, 1'b1);
        checks++; if (level !== 3'd4 || overflow !== 1'b0) begin errors++; $display("FAIL fullpp level=%0d ovf=%b exp=4/0", level, overflow); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (dout !== exp[k]) begin errors++; $display("FAIL fullpp_order k=%0d got=%h exp=%h", k, dout, exp[k]); end
            cycle(1'b0, 8'h00, 1'b1);
        end
    endtask

    task automatic test_reset_midword();
        do_reset();
        cycle(1'b1, 8'hAA, 1'b0);
        cycle(1'b1, 8'hBB, 1'b0);
        do_reset();
        cycle(1'b1, 8'h01, 1'b0);
        cycle(1'b1, 8'h02, 1'b0);
        cycle(1'b1, 8'h03, 1'b0);
        cycle(1'b1, 8'h04, 1'b0);
        checks++; if (dout !== 32'h01020304 || level !== 3'd1 || overflow !== 1'b0) begin errors++; $display("FAIL midrst dout=%h level=%0d ovf=%b exp=01020304/1/0", dout, level, overflow); end
    endtask

`ifdef WORD_ASM_PARITY_EN
    task automatic test_parity();
        logic [7:0] bytes [8] = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h03};
        do_reset();
        checks++; if (dout_par !== 1'b0) begin errors++; $display("FAIL par_empty got=%b exp=0", dout_par); end
        for (int i = 0; i < 8; i++) cycle(1'b1, bytes[i], 1'b0);
        checks++; if (dout !== 32'h1 || dout_par !== 1'b1) begin errors++; $display("FAIL par_w1 dout=%h par=%b exp=00000001/1", dout, dout_par); end
        cycle(1'b0, 8'h00, 1'b1);
        checks++; if (dout !== 32'h3 || dout_par !== 1'b0) begin errors++; $display("FAIL par_w2 dout=%h par=%b exp=00000003/0", dout, dout_par); end
    endtask
`endif

    task automatic test_random();
        logic [31:0] exp_dout;
        logic        en, rdy;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            en  = 1'($urandom_range(0, 1));
            // Starve the output in the first phase to exercise full/overflow.
            rdy = (n < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            cycle(en, 8'($urandom), rdy);
            exp_dout = (mq.size() > 0) ? mq[0] : 32'h0;
            checks++; if (dout !== exp_dout) begin errors++; $display("FAIL rand_dout n=%0d got=%h exp=%h", n, dout, exp_dout); end
            checks++; if (dout_vld !== (mq.size() > 0)) begin errors++; $display("FAIL rand_vld n=%0d got=%b exp=%b", n, dout_vld, mq.size() > 0); end
            checks++; if (level !== 3'(mq.size())) begin errors++; $display("FAIL rand_level n=%0d got=%0d exp=%0d", n, level, mq.size()); end
            checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rand_ovf n=%0d got=%b exp=%b", n, overflow, m_ovf); end
`ifdef WORD_ASM_PARITY_EN
            checks++; if (dout_par !== ^exp_dout) begin errors++; $display("FAIL rand_par n=%0d got=%b exp=%b", n, dout_par, ^exp_dout); end
`endif
        end
    endtask

    initial begin
        rst      = 1'b1;
        din      = 8'h00;
        din_en   = 1'b0;
        dout_rdy = 1'b0;
        m_ovf    = 1'b0;
        test_reset();
        test_basic();
        test_gaps();
        test_overflow();
        test_full_push_pop();
        test_reset_midword();
`ifdef WORD_ASM_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
